// File: rtl/alu_operand_stage.sv
// ALU operand stage: 32x32 register file with optional writeback bypass,
// feeding a single-entry valid/ready output register toward the ALU.
module alu_operand_stage #(
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    input  logic        use_imm,
    input  logic [3:0]  alu_ctrl_in,
    input  logic [4:0]  rd_in,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ainn,
    output logic [31:0] bin,
    output logic [3:0]  alu_ctrll,
    output logic [4:0]  rd_out
);

    // x0 has no storage; it is hardwired to zero in the read logic.
    logic [31:0] regs [1:31];
    logic [31:0] opa_read;
    logic [31:0] opb_read;
    logic [31:0] opb_sel;
    logic        accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        opa_read = '0;
        if (rs1 != 5'd0) begin
            if ((BYPASS != 0) && wb_en && (wb_rd == rs1))
                opa_read = wb_data;
            else
                opa_read = regs[rs1];
        end
    end

    always_comb begin
        opb_read = '0;
        if (rs2 != 5'd0) begin
            if ((BYPASS != 0) && wb_en && (wb_rd == rs2))
                opb_read = wb_data;
            else
                opb_read = regs[rs2];
        end
    end

    // The immediate path never sees the bypass.
    assign opb_sel = use_imm ? imm : opb_read;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++)
                regs[i] <= '0;
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Data registers load only on accept, so operands hold through stalls
    // and are never refreshed by later writebacks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ainn      <= '0;
            bin       <= '0;
            alu_ctrll <= '0;
            rd_out    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            ainn      <= opa_read;
            bin       <= opb_sel;
            alu_ctrll <= alu_ctrl_in;
            rd_out    <= rd_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed table, hand sequences
// and randomized traffic against a behavioural model (BYPASS=1 and BYPASS=0).
module tb_alu_operand_stage;

    typedef struct {
        logic        in_valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        out_ready;
        logic        e_valid;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [3:0]  e_ctrl;
        logic [4:0]  e_rd;
        logic [31:0] e_a_nb;
        logic [31:0] e_b_nb;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic [3:0]  alu_ctrl_in;
    logic [4:0]  rd_in;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_ready;

    logic        in_ready, in_ready_nb;
    logic        out_valid, out_valid_nb;
    logic [31:0] ainn, ainn_nb, bin, bin_nb;
    logic [3:0]  alu_ctrll, alu_ctrll_nb;
    logic [4:0]  rd_out, rd_out_nb;

    int checks = 0;
    int fails  = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_a, m_b, m_a_nb, m_b_nb;
    logic [3:0]  m_ctrl;
    logic [4:0]  m_rd;

    vec_t tbl [8];

    alu_operand_stage #(.BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .imm(imm), .use_imm(use_imm),
        .alu_ctrl_in(alu_ctrl_in), .rd_in(rd_in), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .ainn(ainn), .bin(bin), .alu_ctrll(alu_ctrll), .rd_out(rd_out)
    );

    alu_operand_stage #(.BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nb),
        .rs1(rs1), .rs2(rs2), .imm(imm), .use_imm(use_imm),
        .alu_ctrl_in(alu_ctrl_in), .rd_in(rd_in), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(out_valid_nb), .out_ready(out_ready),
        .ainn(ainn_nb), .bin(bin_nb), .alu_ctrll(alu_ctrll_nb), .rd_out(rd_out_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [4:0] idx, input bit byp);
        if (idx == 5'd0) return 32'h0;
        if (byp && wb_en && wb_rd == idx) return wb_data;
        return m_regs[idx];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_valid = 1'b0;
        m_a = '0; m_b = '0; m_a_nb = '0; m_b_nb = '0; m_ctrl = '0; m_rd = '0;
    endtask

    // One clock of the abstract model: reads see the pre-edge register file.
    task automatic modelStep();
        bit acc;
        acc = in_valid && (!m_valid || out_ready);
        if (acc) begin
            m_a    = modelRead(rs1, 1'b1);
            m_a_nb = modelRead(rs1, 1'b0);
            m_b    = use_imm ? imm : modelRead(rs2, 1'b1);
            m_b_nb = use_imm ? imm : modelRead(rs2, 1'b0);
            m_ctrl = alu_ctrl_in;
            m_rd   = rd_in;
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
    endtask

    function automatic vec_t modelExp();
        vec_t e;
        e = '{default: '0};
        e.e_valid = m_valid; e.e_a = m_a; e.e_b = m_b; e.e_ctrl = m_ctrl;
        e.e_rd = m_rd; e.e_a_nb = m_a_nb; e.e_b_nb = m_b_nb;
        return e;
    endfunction

    function automatic vec_t mkOp(input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                                  input logic [31:0] im, input logic ui, input logic [3:0] c,
                                  input logic [4:0] d, input logic we, input logic [4:0] wr,
                                  input logic [31:0] wd, input logic ordy);
        vec_t v;
        v = '{default: '0};
        v.in_valid = iv; v.rs1 = r1; v.rs2 = r2; v.imm = im; v.use_imm = ui;
        v.ctrl = c; v.rd = d; v.wb_en = we; v.wb_rd = wr; v.wb_data = wd; v.out_ready = ordy;
        return v;
    endfunction

    // Drives one cycle of inputs, checks in_ready, advances model and clock.
    task automatic applyStimulus(input vec_t v);
        in_valid = v.in_valid; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm; use_imm = v.use_imm;
        alu_ctrl_in = v.ctrl; rd_in = v.rd; wb_en = v.wb_en; wb_rd = v.wb_rd;
        wb_data = v.wb_data; out_ready = v.out_ready;
        #1;
        checkVal("in_ready", {31'h0, in_ready}, {31'h0, (!m_valid || out_ready)});
        checkVal("in_ready_nb", {31'h0, in_ready_nb}, {31'h0, (!m_valid || out_ready)});
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t e);
        checkVal("out_valid", {31'h0, out_valid}, {31'h0, e.e_valid});
        checkVal("ainn", ainn, e.e_a);
        checkVal("bin", bin, e.e_b);
        checkVal("alu_ctrll", {28'h0, alu_ctrll}, {28'h0, e.e_ctrl});
        checkVal("rd_out", {27'h0, rd_out}, {27'h0, e.e_rd});
        checkVal("out_valid_nb", {31'h0, out_valid_nb}, {31'h0, e.e_valid});
        checkVal("ainn_nb", ainn_nb, e.e_a_nb);
        checkVal("bin_nb", bin_nb, e.e_b_nb);
        checkVal("rd_out_nb", {27'h0, rd_out_nb}, {27'h0, e.e_rd});
    endtask

    initial begin
        vec_t v;
        vec_t ref_op;

        // Directed vectors with hand-derived expectations
        tbl[0] = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 4'h0, 5'd0, 1'b1, 5'd5, 32'h0000_0010, 1'b1,
                   1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 5'd5, 5'd0, 32'hFFFF_FFFC, 1'b1, 4'b0010, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1,
                   1'b1, 32'h10, 32'hFFFF_FFFC, 4'b0010, 5'd3, 32'h10, 32'hFFFF_FFFC};
        tbl[2] = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 4'h0, 5'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b1,
                   1'b0, 32'h10, 32'hFFFF_FFFC, 4'b0010, 5'd3, 32'h10, 32'hFFFF_FFFC};
        tbl[3] = '{1'b1, 5'd0, 5'd5, 32'h0, 1'b0, 4'b0001, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1,
                   1'b1, 32'h0, 32'h10, 4'b0001, 5'd4, 32'h0, 32'h10};
        tbl[4] = '{1'b1, 5'd5, 5'd7, 32'h0, 1'b0, 4'b0110, 5'd9, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1,
                   1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0110, 5'd9, 32'h10, 32'h0};
        tbl[5] = '{1'b1, 5'd7, 5'd0, 32'h5, 1'b1, 4'b0111, 5'd1, 1'b1, 5'd7, 32'h0000_CAFE, 1'b1,
                   1'b1, 32'hCAFE, 32'h5, 4'b0111, 5'd1, 32'hDEAD_BEEF, 32'h5};
        tbl[6] = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0,
                   1'b1, 32'hCAFE, 32'h5, 4'b0111, 5'd1, 32'hDEAD_BEEF, 32'h5};
        tbl[7] = '{1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 4'h0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1,
                   1'b0, 32'hCAFE, 32'h5, 4'b0111, 5'd1, 32'hDEAD_BEEF, 32'h5};

        rst_n = 1'b0; in_valid = 0; rs1 = 0; rs2 = 0; imm = 0; use_imm = 0;
        alu_ctrl_in = 0; rd_in = 0; wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 0;
        modelReset();
        #1;
        checkOutput(modelExp());
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checkVal("in_ready_after_reset", {31'h0, in_ready}, 32'h1);

        $display("[TB] directed table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i]);
        end

        $display("[TB] backpressure");
        applyStimulus(mkOp(1, 5'd5, 5'd7, 32'h0, 0, 4'b1111, 5'd10, 0, 5'd0, 32'h0, 1));
        checkOutput(modelExp());
        ref_op = modelExp();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mkOp(1, 5'd7, 5'd5, 32'h0, 0, 4'b1100, 5'd11, 1, 5'd5, 32'h77, 0));
            checkVal("stall_in_ready", {31'h0, in_ready}, 32'h0);
            checkOutput(ref_op);
        end
        applyStimulus(mkOp(1, 5'd7, 5'd5, 32'h0, 0, 4'b1100, 5'd11, 0, 5'd0, 32'h0, 1));
        checkOutput(modelExp());
        checkVal("release_load_a", ainn, 32'h0000_CAFE);
        checkVal("release_load_b", bin, 32'h77);

        $display("[TB] throughput");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(mkOp(1, 5'(i), 5'(i + 1), 32'(i * 3), 1'(i % 2), 4'(i), 5'(i + 16),
                               1, 5'(i + 20), 32'(i * 32'h101), 1));
            checkVal("thru_valid", {31'h0, out_valid}, 32'h1);
            checkVal("thru_rd", {27'h0, rd_out}, 32'(i + 16));
            checkOutput(modelExp());
        end

        $display("[TB] reset during stall");
        applyStimulus(mkOp(1, 5'd5, 5'd7, 32'h0, 0, 4'b0011, 5'd2, 0, 5'd0, 32'h0, 0));
        rst_n = 1'b0;
        #1;
        checkVal("async_out_valid", {31'h0, out_valid}, 32'h0);
        checkVal("async_ainn", ainn, 32'h0);
        checkVal("async_bin", bin, 32'h0);
        modelReset();
        in_valid = 1; wb_en = 1; wb_rd = 5'd5; wb_data = 32'hFFFF; out_ready = 1;
        @(posedge clk); #1;
        checkOutput(modelExp());
        rst_n = 1'b1;
        applyStimulus(mkOp(1, 5'd5, 5'd7, 32'h0, 0, 4'b1000, 5'd6, 0, 5'd0, 32'h0, 1));
        checkVal("post_reset_valid", {31'h0, out_valid}, 32'h1);
        checkVal("post_reset_a", ainn, 32'h0);
        checkVal("post_reset_b", bin, 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            v = mkOp(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
                     4'($urandom), 5'($urandom), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 3) != 0));
            applyStimulus(v);
            checkOutput(modelExp());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter: BYPASS, default 1, meaning: 1 forwards a same-cycle writeback to the operand read, 0 reads the array only.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream decode presents an operation.
REQ-005 in_ready  output  1  stage can accept an operation this cycle.
REQ-006 rs1  input  5  source register index for operand A.
REQ-007 rs2  input  5  source register index for operand B.
REQ-008 imm  input  32  sign-extended immediate from decode.
REQ-009 use_imm  input  1  1 selects imm as operand B, 0 selects register rs2.
REQ-010 alu_ctrl_in  input  4  ALU op code (ADD 0010, SUB 0110, AND 0000, OR 0001, NOR 1100, SLT 0111, SLL 0011, SRL 1000, SRA 1010, XOR 1111), passed through unmodified.
REQ-011 rd_in  input  5  destination register index, passed through.
REQ-012 wb_en  input  1  register-file write enable from writeback.
REQ-013 wb_rd  input  5  writeback destination index.
REQ-014 wb_data  input  32  writeback data.
REQ-015 out_valid  output  1  registered operation presented to the ALU.
REQ-016 out_ready  input  1  downstream consumes the operation this cycle.
REQ-017 ainn  output  32  registered operand A for the ALU.
REQ-018 bin  output  32  registered operand B for the ALU.
REQ-019 alu_ctrll  output  4  registered ALU op code.
REQ-020 rd_out  output  5  registered destination index.

Function
REQ-021 Register file: 32 x 32-bit; x0 reads 0 always; writes with wb_rd=0 ignored.
REQ-022 Write: on rising edge with wb_en=1 and wb_rd!=0, reg[wb_rd] <= wb_data.
REQ-023 Read: combinational at the accept cycle; value = 0 if index 0; else wb_data if BYPASS=1, wb_en=1, wb_rd==index; else reg[index].
REQ-024 Operand B source: use_imm=1 -> imm (rs2 ignored, no bypass applied); use_imm=0 -> read of rs2 per REQ-023.
REQ-025 Output register is a single-entry pipeline stage; in_ready = !out_valid || out_ready (combinational).
REQ-026 Accept = in_valid && in_ready; on accept edge ainn, bin, alu_ctrll, rd_out load and out_valid <= 1; latency exactly 1 cycle.
REQ-027 out_valid && out_ready && no accept -> out_valid <= 0 next edge; data outputs hold last values.
REQ-028 out_valid && out_ready && accept (simultaneous) -> new operation loads, out_valid stays 1; zero-bubble throughput of 1 op/cycle.
REQ-029 Stall: out_valid=1, out_ready=0 -> all outputs held bit-stable; in_ready=0; upstream holds its inputs.
REQ-030 Held operands are not refreshed by later writebacks; hazard ordering is upstream's responsibility.
REQ-031 in_valid=0 never alters outputs other than out_valid per REQ-027.
REQ-032 Writeback proceeds independently of in_valid, stall, or out_valid.

Reset
REQ-033 rst_n low asynchronously forces out_valid=0, ainn=0, bin=0, alu_ctrll=0000, rd_out=0, and all 32 registers to 0.
REQ-034 rst_n low mid-operation discards the held op; no writeback occurs while rst_n low.
REQ-035 First accept possible on the first rising edge after rst_n deasserts; in_ready=1 out of reset.

Verification
REQ-036 Basic: write x5=0x0000_0010 then op rs1=5, use_imm=1, imm=0xFFFF_FFFC, ctrl 0010 -> next cycle out_valid=1, ainn=0x10, bin=0xFFFF_FFFC, alu_ctrll=0010.
REQ-037 Bypass: same cycle wb_en=1, wb_rd=7, wb_data=0xDEAD_BEEF, accept rs2=7, use_imm=0 -> bin=0xDEAD_BEEF (BYPASS=1); old reg[7] value (BYPASS=0).
REQ-038 x0: wb_en=1, wb_rd=0, wb_data=0x1234 then read rs1=0 -> ainn=0.
REQ-039 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> next op loads on same edge, out_valid stays 1.
REQ-040 Reset mid-stall: rst_n low while out_valid=1 -> out_valid=0 and ainn=0 immediately without clock; reg reads return 0 afterwards.
REQ-041 Throughput: 8 back-to-back ops with out_ready=1 -> 8 consecutive out_valid cycles, operands in order, no bubbles.
